// File: rtl/wb_rr_intercon.sv
// Shared-bus Wishbone classic interconnect: round-robin master arbitration,
// mask/base slave decode, error termination for unmapped or stalled transfers.
module wb_rr_intercon #(
    parameter int                  NUM_M    = 2,
    parameter int                  NUM_S    = 4,
    parameter int                  DW       = 32,
    parameter int                  AW       = 32,
    parameter logic [NUM_S*AW-1:0] SLV_BASE = '0,
    parameter logic [NUM_S*AW-1:0] SLV_MASK = '0,
    parameter int                  TIMEOUT  = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic [NUM_M*AW-1:0]      wbm_adr_i,
    input  logic [NUM_M*DW-1:0]      wbm_dat_i,
    input  logic [NUM_M*(DW/8)-1:0]  wbm_sel_i,
    input  logic [NUM_M-1:0]         wbm_we_i,
    input  logic [NUM_M-1:0]         wbm_cyc_i,
    input  logic [NUM_M-1:0]         wbm_stb_i,
    output logic [DW-1:0]            wbm_dat_o,
    output logic [NUM_M-1:0]         wbm_ack_o,
    output logic [NUM_M-1:0]         wbm_err_o,

    output logic [AW-1:0]            wbs_adr_o,
    output logic [DW-1:0]            wbs_dat_o,
    output logic [(DW/8)-1:0]        wbs_sel_o,
    output logic                     wbs_we_o,
    output logic [NUM_S-1:0]         wbs_cyc_o,
    output logic [NUM_S-1:0]         wbs_stb_o,
    input  logic [NUM_S*DW-1:0]      wbs_dat_i,
    input  logic [NUM_S-1:0]         wbs_ack_i,
    input  logic [NUM_S-1:0]         wbs_err_i
);

    localparam int SW = DW / 8;
    localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SIW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [MW-1:0] LAST_M = MW'(NUM_M - 1);
    localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   grant_q, grant_d;
    logic [MW-1:0]   last_q, last_d;
    logic [TW-1:0]   wdog_q, wdog_d;

    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [SW-1:0]   g_sel;
    logic            g_we;
    logic            g_cyc;
    logic            g_stb;

    logic            s_hit;
    logic [SIW-1:0]  s_idx;
    logic            s_ack;
    logic            s_err;
    logic [DW-1:0]   s_dat;

    logic            req_any;
    logic [MW-1:0]   next_m;
    logic            busy;
    logic            stall;
    logic            timeout;

    always_comb begin
        g_adr = wbm_adr_i[int'(grant_q)*AW +: AW];
        g_dat = wbm_dat_i[int'(grant_q)*DW +: DW];
        g_sel = wbm_sel_i[int'(grant_q)*SW +: SW];
        g_we  = wbm_we_i[grant_q];
        g_cyc = wbm_cyc_i[grant_q];
        g_stb = wbm_stb_i[grant_q];
    end

    // Scan downward so the lowest-index matching slave is the last one written.
    always_comb begin
        s_hit = 1'b0;
        s_idx = '0;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if ((g_adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                s_hit = 1'b1;
                s_idx = SIW'(i);
            end
        end
    end

    always_comb begin
        s_ack = wbs_ack_i[s_idx];
        s_err = wbs_err_i[s_idx];
        s_dat = wbs_dat_i[int'(s_idx)*DW +: DW];
    end

    // Round-robin: nearest requester after the last owner wins, so the
    // smallest offset is evaluated last.
    always_comb begin
        req_any = 1'b0;
        next_m  = last_q;
        for (int i = NUM_M; i >= 1; i--) begin
            if (wbm_cyc_i[(int'(last_q) + i) % NUM_M]) begin
                req_any = 1'b1;
                next_m  = MW'((int'(last_q) + i) % NUM_M);
            end
        end
    end

    // A transfer is stb high until the selected slave answers with ack or err;
    // cyc framing alone keeps the bus owned between transfers.
    always_comb begin
        busy    = (state_q == BUSY);
        stall   = busy && s_hit && g_cyc && g_stb && !s_ack && !s_err;
        timeout = stall && (wdog_q == WD_LIMIT);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = '0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d = next_m;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (g_stb && !s_hit) begin
                    state_d = ERR;
                end else if (timeout) begin
                    state_d = ERR;
                end else if (stall) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ERR: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else begin
                    state_d = BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_M;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // Timed-out strobes are withdrawn from the slave in the same cycle.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        wbm_dat_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        if (busy) begin
            wbs_adr_o = g_adr;
            wbs_dat_o = g_dat;
            wbs_sel_o = g_sel;
            wbs_we_o  = g_we;
            if (s_hit) begin
                wbs_cyc_o[s_idx]   = g_cyc && !timeout;
                wbs_stb_o[s_idx]   = g_stb && !timeout;
                wbm_dat_o          = s_dat;
                wbm_ack_o[grant_q] = s_ack && !s_err;
                wbm_err_o[grant_q] = s_err;
            end
        end else if (state_q == ERR) begin
            wbm_err_o[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_rr_intercon.sv
// Bench for wb_rr_intercon: directed scenarios plus randomized traffic, all
// checked each cycle against a transaction-style owner/rotation model.
module tb_wb_rr_intercon;
  localparam int NUM_M   = 2;
  localparam int NUM_S   = 2;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 4;
  localparam logic [NUM_S*AW-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000};
  localparam logic [NUM_S*AW-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000};

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NUM_M*AW-1:0] wbm_adr_i = '0;
  logic [NUM_M*DW-1:0] wbm_dat_i = '0;
  logic [NUM_M*SW-1:0] wbm_sel_i = '0;
  logic [NUM_M-1:0]    wbm_we_i  = '0;
  logic [NUM_M-1:0]    wbm_cyc_i = '0;
  logic [NUM_M-1:0]    wbm_stb_i = '0;
  logic [DW-1:0]       wbm_dat_o;
  logic [NUM_M-1:0]    wbm_ack_o;
  logic [NUM_M-1:0]    wbm_err_o;
  logic [AW-1:0]       wbs_adr_o;
  logic [DW-1:0]       wbs_dat_o;
  logic [SW-1:0]       wbs_sel_o;
  logic                wbs_we_o;
  logic [NUM_S-1:0]    wbs_cyc_o;
  logic [NUM_S-1:0]    wbs_stb_o;
  logic [NUM_S*DW-1:0] wbs_dat_i = '0;
  logic [NUM_S-1:0]    wbs_ack_i = '0;
  logic [NUM_S-1:0]    wbs_err_i = '0;

  wb_rr_intercon #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .DW(DW), .AW(AW),
    .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  logic [NUM_M-1:0] exp_q[$];

  // reference model: who owns the bus, whether an error beat is owed,
  // who owned it last, and how many cycles the current strobe has waited
  int m_owner = -1;
  bit m_in_err = 1'b0;
  int m_ptr = NUM_M - 1;
  int m_stall = 0;

  // slave responder: manual (bench sets ack/err) or auto (answers strobes)
  bit auto_slv = 1'b0;
  int ack_pct = 100;
  int err_pct = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc_n, got, exp);
    end
  endtask

  // address map: 0x0000_xxxx -> slave 0, 0x0001_xxxx -> slave 1, else none
  function automatic int region(input logic [AW-1:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:16] == 16'h0001) return 1;
    return -1;
  endfunction

  task automatic compare_all();
    logic [NUM_S-1:0] e_cyc, e_stb;
    logic [NUM_M-1:0] e_ack, e_err;
    logic [DW-1:0] e_rdat, e_wdat;
    logic [AW-1:0] e_adr;
    logic [SW-1:0] e_sel;
    logic e_we, c, s, a, e, to;
    int slv;
    e_cyc = '0; e_stb = '0; e_ack = '0; e_err = '0;
    e_rdat = '0; e_wdat = '0; e_adr = '0; e_sel = '0; e_we = 1'b0;
    if (m_owner >= 0 && m_in_err) begin
      e_err[m_owner] = 1'b1;
    end else if (m_owner >= 0) begin
      e_adr  = wbm_adr_i[m_owner*AW +: AW];
      e_wdat = wbm_dat_i[m_owner*DW +: DW];
      e_sel  = wbm_sel_i[m_owner*SW +: SW];
      e_we   = wbm_we_i[m_owner];
      c = wbm_cyc_i[m_owner];
      s = wbm_stb_i[m_owner];
      slv = region(e_adr);
      if (slv >= 0) begin
        a = wbs_ack_i[slv];
        e = wbs_err_i[slv];
        to = c && s && !a && !e && (m_stall == TIMEOUT - 1);
        e_cyc[slv] = c && !to;
        e_stb[slv] = s && !to;
        e_rdat = wbs_dat_i[slv*DW +: DW];
        e_ack[m_owner] = a && !e;
        e_err[m_owner] = e;
      end
    end
    check_eq("wbs_cyc", wbs_cyc_o, e_cyc);
    check_eq("wbs_stb", wbs_stb_o, e_stb);
    check_eq("wbs_adr", wbs_adr_o, e_adr);
    check_eq("wbs_dat", wbs_dat_o, e_wdat);
    check_eq("wbs_sel", wbs_sel_o, e_sel);
    check_eq("wbs_we", wbs_we_o, e_we);
    check_eq("wbm_dat", wbm_dat_o, e_rdat);
    check_eq("wbm_ack", wbm_ack_o, e_ack);
    check_eq("wbm_err", wbm_err_o, e_err);
  endtask

  task automatic model_step();
    int slv;
    bit found;
    if (rst_i) begin
      m_owner = -1; m_in_err = 1'b0; m_ptr = NUM_M - 1; m_stall = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_M; k++) begin
        if (!found && wbm_cyc_i[(m_ptr + k) % NUM_M]) begin
          found = 1'b1;
          m_owner = (m_ptr + k) % NUM_M;
        end
      end
      m_stall = 0;
    end else if (m_in_err) begin
      m_in_err = 1'b0;
      if (!wbm_cyc_i[m_owner]) begin m_ptr = m_owner; m_owner = -1; end
    end else begin
      slv = region(wbm_adr_i[m_owner*AW +: AW]);
      if (!wbm_cyc_i[m_owner]) begin
        m_ptr = m_owner; m_owner = -1; m_stall = 0;
      end else if (wbm_stb_i[m_owner] && slv < 0) begin
        m_in_err = 1'b1; m_stall = 0;
      end else if (wbm_stb_i[m_owner] && !wbs_ack_i[slv] && !wbs_err_i[slv]) begin
        m_stall++;
        if (m_stall == TIMEOUT) begin m_in_err = 1'b1; m_stall = 0; end
      end else begin
        m_stall = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_m(input int m, input bit cyc, input bit stb, input bit we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
    wbm_cyc_i[m] = cyc;
    wbm_stb_i[m] = stb;
    wbm_we_i[m]  = we;
    wbm_adr_i[m*AW +: AW] = adr;
    wbm_dat_i[m*DW +: DW] = dat;
    wbm_sel_i[m*SW +: SW] = sel;
  endtask

  task automatic drive_s(input int s, input bit ack, input bit err, input logic [DW-1:0] dat);
    wbs_ack_i[s] = ack;
    wbs_err_i[s] = err;
    wbs_dat_i[s*DW +: DW] = dat;
  endtask

  task automatic idle_all();
    for (int m = 0; m < NUM_M; m++) drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int s = 0; s < NUM_S; s++) drive_s(s, 1'b0, 1'b0, '0);
  endtask

  task automatic settle();
    if (auto_slv) begin
      wbs_ack_i = '0;
      wbs_err_i = '0;
    end
    #1;
    if (auto_slv) begin
      for (int s = 0; s < NUM_S; s++) begin
        wbs_dat_i[s*DW +: DW] = $urandom();
        wbs_ack_i[s] = wbs_stb_o[s] && ($urandom_range(0, 99) < ack_pct);
        wbs_err_i[s] = wbs_stb_o[s] && ($urandom_range(0, 99) < err_pct);
      end
    end
    #1;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    cyc_n++;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle_all();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic rand_masters();
    int r;
    logic [15:0] hi;
    for (int m = 0; m < NUM_M; m++) begin
      if (wbm_cyc_i[m]) begin
        if ($urandom_range(0, 99) < 15) wbm_cyc_i[m] = 1'b0;
      end else if ($urandom_range(0, 99) < 40) begin
        wbm_cyc_i[m] = 1'b1;
      end
      wbm_stb_i[m] = wbm_cyc_i[m] && ($urandom_range(0, 99) < 75);
      wbm_we_i[m] = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 9);
      hi = (r < 5) ? 16'h0000 : (r < 9) ? 16'h0001 : 16'(16'h0002 + $urandom_range(0, 100));
      wbm_adr_i[m*AW +: AW] = {hi, 16'($urandom())};
      wbm_dat_i[m*DW +: DW] = $urandom();
      wbm_sel_i[m*SW +: SW] = SW'($urandom());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL time_limit: simulation exceeded its time budget");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_M-1:0] oh;
    @(negedge clk_i);

    // reset state
    do_reset();
    settle();
    check_eq("rst_cyc", wbs_cyc_o, '0);
    check_eq("rst_ack", wbm_ack_o, '0);
    check_eq("rst_err", wbm_err_o, '0);
    check_eq("rst_rdat", wbm_dat_o, '0);
    tick();

    // single read from slave1 with zero-wait ack
    auto_slv = 1'b0;
    drive_s(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0001_0004, '0, 4'hF);
    settle();
    check_eq("rd_arb_cyc", wbs_cyc_o, 2'b00);
    tick();
    settle();
    check_eq("rd_cyc", wbs_cyc_o, 2'b10);
    check_eq("rd_data", wbm_dat_o, 32'hDEAD_BEEF);
    check_eq("rd_ack", wbm_ack_o, 2'b01);
    tick();
    idle_all();
    settle(); tick();
    settle(); tick();

    // rotation with both masters requesting from reset
    do_reset();
    auto_slv = 1'b1; ack_pct = 100; err_pct = 0;
    for (int r = 0; r < 4; r++) exp_q.push_back(NUM_M'(1) << (r % NUM_M));
    for (int r = 0; r < 4; r++) begin
      drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, '0, 4'hF);
      drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, '0, 4'hF);
      settle();
      check_eq("rot_gap_ack", wbm_ack_o, '0);
      tick();
      oh = exp_q.pop_front();
      settle();
      check_eq("rot_owner_ack", wbm_ack_o, oh);
      tick();
      for (int m = 0; m < NUM_M; m++) if (oh[m]) drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      settle();
      check_eq("rot_drop_ack", wbm_ack_o, '0);
      tick();
    end
    idle_all(); settle(); tick();

    // M1 write burst holds the bus while M0 waits
    do_reset();
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'hA000_0000, 4'h3);
    settle(); tick();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0001_0000, '0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      drive_m(1, 1'b1, 1'b1, 1'b1, AW'(k * 4), DW'(32'hA000_0000 + k), SW'(4'h3 << k));
      settle();
      check_eq("burst_ack", wbm_ack_o, 2'b10);
      check_eq("burst_cyc", wbs_cyc_o, 2'b01);
      check_eq("burst_sel", wbs_sel_o, SW'(4'h3 << k));
      check_eq("burst_wdat", wbs_dat_o, DW'(32'hA000_0000 + k));
      tick();
    end
    drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle(); check_eq("burst_end_ack", wbm_ack_o, '0); tick();
    settle(); check_eq("burst_gap_ack", wbm_ack_o, '0); tick();
    settle();
    check_eq("burst_m0_ack", wbm_ack_o, 2'b01);
    check_eq("burst_m0_cyc", wbs_cyc_o, 2'b10);
    tick();
    idle_all(); settle(); tick();

    // unmapped address
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0002_0000, '0, 4'hF);
    settle(); tick();
    settle();
    check_eq("unmap_busy_err", wbm_err_o, '0);
    check_eq("unmap_busy_cyc", wbs_cyc_o, '0);
    tick();
    settle();
    check_eq("unmap_err", wbm_err_o, 2'b01);
    check_eq("unmap_err_cyc", wbs_cyc_o, '0);
    tick();
    drive_m(0, 1'b1, 1'b0, 1'b0, 32'h0002_0000, '0, 4'hF);
    settle(); check_eq("unmap_err_once", wbm_err_o, '0); tick();
    idle_all(); settle(); tick();

    // watchdog: slave0 never answers
    do_reset();
    auto_slv = 1'b0;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, '0, 4'hF);
    settle(); tick();
    for (int k = 1; k < TIMEOUT; k++) begin
      settle();
      check_eq("wd_stall_cyc", wbs_cyc_o, 2'b01);
      tick();
    end
    settle();
    check_eq("wd_drop_cyc", wbs_cyc_o, '0);
    check_eq("wd_drop_stb", wbs_stb_o, '0);
    tick();
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle(); check_eq("wd_err", wbm_err_o, 2'b01); tick();
    settle(); tick();
    // second run: ack lands in the timeout cycle
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, '0, 4'hF);
    settle(); tick();
    for (int k = 1; k < TIMEOUT; k++) begin settle(); tick(); end
    drive_s(0, 1'b1, 1'b0, 32'h1234_5678);
    settle();
    check_eq("wd_late_ack", wbm_ack_o, 2'b01);
    check_eq("wd_late_cyc", wbs_cyc_o, 2'b01);
    check_eq("wd_late_data", wbm_dat_o, 32'h1234_5678);
    tick();
    idle_all();
    settle(); check_eq("wd_late_no_err", wbm_err_o, '0); tick();

    // reset in the middle of M0's transfer
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0004, '0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0008, '0, 4'hF);
    settle(); tick();
    settle(); check_eq("mid_pending_cyc", wbs_cyc_o, 2'b01); tick();
    drive_s(0, 1'b1, 1'b0, 32'h5555_AAAA);
    rst_i = 1'b1;
    settle(); tick();
    rst_i = 1'b0;
    settle();
    check_eq("mid_rst_cyc", wbs_cyc_o, '0);
    check_eq("mid_rst_stb", wbs_stb_o, '0);
    check_eq("mid_rst_ack", wbm_ack_o, '0);
    check_eq("mid_rst_adr", wbs_adr_o, '0);
    check_eq("mid_rst_rdat", wbm_dat_o, '0);
    tick();
    settle(); check_eq("mid_regrant_m0", wbm_ack_o, 2'b01); tick();
    idle_all(); settle(); tick();

    // randomized traffic against the model
    do_reset();
    auto_slv = 1'b1; ack_pct = 40; err_pct = 8;
    for (int i = 0; i < 3000; i++) begin
      rand_masters();
      rst_i = ($urandom_range(0, 199) == 0);
      settle();
      tick();
    end
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_rr_intercon.md
Name: wb_rr_intercon

Overview:
Parametrised Wishbone classic interconnect for the Muskoka SoC.
- Connects NUM_M masters (moxie core, future DMA/debug) to NUM_S slaves through a single shared bus.
- Round-robin arbitration between masters, mask/base address decoding to slaves.
- Error termination for unmapped addresses, plus a per-transfer watchdog timeout.

Parameters:
NUM_M, 2, number of masters (1..8)
NUM_S, 4, number of slaves (1..16)
DW, 32, data width; select width SW = DW/8
AW, 32, address width
SLV_BASE, {NUM_S*AW{1'b0}}, packed base addresses, slave i at bits [i*AW +: AW]
SLV_MASK, {NUM_S*AW{1'b0}}, packed decode masks, same packing as SLV_BASE
TIMEOUT, 255, watchdog cycles before error termination (>=2); counter width clog2(TIMEOUT+1)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
wbm_adr_i  in  NUM_M*AW  master addresses, packed
wbm_dat_i  in  NUM_M*DW  master write data, packed
wbm_sel_i  in  NUM_M*SW  master byte selects
wbm_we_i  in  NUM_M  master write enables
wbm_cyc_i  in  NUM_M  master cycle requests
wbm_stb_i  in  NUM_M  master strobes
wbm_dat_o  out  DW  read data, shared by all masters
wbm_ack_o  out  NUM_M  per-master ack
wbm_err_o  out  NUM_M  per-master error
wbs_adr_o  out  AW  shared slave address
wbs_dat_o  out  DW  shared slave write data
wbs_sel_o  out  SW  shared slave selects
wbs_we_o  out  1  shared slave write enable
wbs_cyc_o  out  NUM_S  per-slave cycle
wbs_stb_o  out  NUM_S  per-slave strobe
wbs_dat_i  in  NUM_S*DW  slave read data, packed
wbs_ack_i  in  NUM_S  slave acks
wbs_err_i  in  NUM_S  slave errors

Behaviour:
- Reset (rst_i high at clk_i edge):
  - State goes to IDLE, no grant, last-grant pointer = NUM_M-1, watchdog = 0.
  - All outputs 0: wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbm_dat_o.
  - Reset mid-transfer drops every slave cyc/stb in the following cycle; the in-flight ack is discarded.
- FSM states: IDLE, BUSY, ERR.
  - IDLE: if any wbm_cyc_i is high, grant the first requester found scanning from last_grant+1 upward, wrapping modulo NUM_M. Grant is registered; go to BUSY next cycle. This gives 1 cycle of arbitration latency.
  - BUSY: the granted master's adr/dat/sel/we drive wbs_* combinationally. Only the decoded slave sees cyc=granted cyc and stb=granted stb; all other slaves see 0.
    - Slave ack/err/dat are routed combinationally to the granted master only; other masters see ack=err=0.
    - Grant is held across multiple transfers while the granted master keeps cyc high, giving burst/RMW atomicity.
    - Granted cyc low: return to IDLE, last_grant <= granted index. A new grant is possible on the next IDLE cycle, so there is 1 dead cycle between owners.
  - BUSY, no slave match, granted stb high: go to ERR.
  - ERR: assert wbm_err_o of the granted master for exactly 1 cycle; no slave cyc/stb. Return to BUSY if cyc is still high, else IDLE with last_grant updated.
- Decode:
  - Slave i matches when (adr & SLV_MASK[i]) == SLV_BASE[i].
  - With multiple matches, the lowest index wins.
  - An all-zero mask matches everything, used as the default slave.
- Watchdog:
  - Counts cycles in BUSY with granted stb high and no ack/err from the selected slave; clears on ack, err, stb low, or leaving BUSY.
  - On reaching TIMEOUT: drop slave cyc/stb that cycle and go to ERR.
  - A slave ack arriving in the same cycle as the timeout takes priority; the watchdog is ignored.
- Simultaneous events:
  - Ack and err from the slave in the same cycle: err wins, ack is suppressed.
  - All masters requesting continuously are served strictly in rotation.
- Single master (NUM_M=1): grant is still registered and the 1-cycle latency is kept.
- wbm_dat_o carries the selected slave's data while a slave is selected in BUSY, else 0.

Test Plan:
- NUM_M=2, NUM_S=2, slave0 base 0x00000000 mask 0xFFFF0000, slave1 base 0x00010000 mask 0xFFFF0000. M0 reads 0x00010004 while slave1 returns 0xDEADBEEF with 0-wait ack -> wbs_cyc_o=2'b10, wbm_dat_o=0xDEADBEEF, wbm_ack_o=2'b01, grant visible 1 cycle after cyc.
- M0 and M1 raise cyc in the same cycle from reset -> M0 granted first (pointer=1 wraps to 0). After M0 drops cyc: 1 IDLE cycle, then M1 granted. Repeat -> M0, M1, M0 alternation.
- M1 holds cyc across 3 writes to 0x00000000/4/8 while M0 requests -> M0 stalls until M1 drops cyc; all 3 acks go to M1 only, and slave0 sees sel/dat from M1.
- M0 accesses 0x00020000 (unmapped) -> no wbs_cyc_o, wbm_err_o[0] high for exactly 1 cycle, 2 cycles after stb in BUSY.
- TIMEOUT=4, slave0 never acks -> wbm_err_o[0] asserted after 4 stalled cycles, slave0 cyc/stb drop. A second run with ack on cycle 4 -> ack delivered, no err.
- Assert rst_i mid-transfer with slave ack pending -> next cycle all outputs 0, state IDLE; the subsequent request is granted to M0 again.
